gpmc_mbox_bank: RTL and testbench
=================================

Name: gpmc_mbox_bank

Overview:
- Parametrised GPMC-mapped mailbox. Provides NUM_CH independent channels; each channel has a host-to-fabric TX FIFO and a fabric-to-host RX FIFO, plus per-channel status, control and level registers.
- Sits behind gpmc_sync on its cs/we/oe/address/data_out/data_in bus, all signals in the clk domain.
- Replaces the flat scratch-RAM example with buffered, flow-controlled channels for the UART and streaming designs.

Parameters:
- DATA_WIDTH, 16: GPMC word and FIFO data width.
- ADDR_WIDTH, 4: word-address width from gpmc_sync. Must be >= CH_BITS+2.
- NUM_CH, 2: channel count, 1..8.
- FIFO_DEPTH, 8: entries per FIFO. Power of two, 2..128.
- CH_BITS is local: clog2(NUM_CH), minimum 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- cs  in  1  gpmc_sync chip select, active low.
- we  in  1  gpmc_sync write strobe, active low.
- oe  in  1  gpmc_sync output enable, active low.
- address  in  ADDR_WIDTH  word address.
- data_out  in  DATA_WIDTH  host write data.
- data_in  out  DATA_WIDTH  host read data, registered.
- tx_data  out  NUM_CH*DATA_WIDTH  TX FIFO head per channel; channel c occupies [c*DATA_WIDTH +: DATA_WIDTH].
- tx_valid  out  NUM_CH  TX FIFO non-empty.
- tx_ready  in  NUM_CH  fabric accepts TX head.
- rx_data  in  NUM_CH*DATA_WIDTH  fabric data into the RX FIFO.
- rx_valid  in  NUM_CH  fabric offers an RX word.
- rx_ready  out  NUM_CH  RX FIFO not full.
- irq  out  1  present only with GPMC_MBOX_IRQ_EN.

Behaviour:
- Strobe qualification:
  - wr_act = !cs && !we && oe.
  - rd_act = !cs && we && !oe.
  - Registered previous values give edges: wr_stb = wr_act && !wr_act_q; rd_stb likewise.
  - Exactly one side-effect per GPMC access, however many clk cycles the strobe lasts.
- Address decode:
  - ch = address[CH_BITS+1:2]; off = address[1:0].
  - ch >= NUM_CH, or any address bit above CH_BITS+1 set: reads return 0, writes ignored, no side-effects.
- Register map per channel:
  - off 0 DATA:
    - Write pushes data_out into TX. If TX is full, the word is dropped and TX_OVF is set.
    - Read pops RX and returns the head. If RX is empty, it returns 0 and sets RX_UDF.
  - off 1 STATUS (read-only):
    - bit0 TX_FULL, bit1 TX_EMPTY, bit2 RX_FULL, bit3 RX_EMPTY, bit4 TX_OVF (sticky), bit5 RX_UDF (sticky), others 0.
  - off 2 CTRL:
    - Write bit0 flushes TX; bit1 flushes RX; bit3 clears TX_OVF; bit4 clears RX_UDF.
    - bit2 IRQ_EN is stored and reads back; other bits read 0.
  - off 3 LEVEL (read-only): [7:0] = TX count, [15:8] = RX count, counts 0..FIFO_DEPTH.
- Read timing:
  - data_in is loaded on the rd_stb cycle from the pre-pop state. It is valid from the next clk edge and held while rd_act stays high.
  - data_in is 0 on any cycle where rd_act is low (registered).
- FIFO rules:
  - TX pops on tx_valid && tx_ready. tx_data is the current head, combinational from storage.
  - RX pushes on rx_valid && rx_ready.
  - Host push and fabric pop in the same cycle: both occur, level unchanged; also legal when full.
  - Fabric push and host pop in the same cycle: both occur, level unchanged.
  - Pointers wrap modulo FIFO_DEPTH; the count register resolves full versus empty.
  - A flush in the same cycle as a push or pop: flush wins, count 0, pointers 0, sticky flags untouched.
- Reset (asynchronous, any time, including mid-access):
  - All pointers, counts, stickies, IRQ_EN, wr_act_q and rd_act_q clear.
  - data_in = 0, tx_valid = 0, rx_ready = all ones, irq = 0.
  - A strobe already active when reset releases is not treated as a new edge; it needs a fresh edge.

Optional Feature:
- GPMC_MBOX_IRQ_EN defined:
  - irq is registered: irq = OR over c of (IRQ_EN[c] && (!RX_EMPTY[c] || TX_OVF[c] || RX_UDF[c])).
  - irq updates one clk after the cause changes.
- Undefined: no irq port; IRQ_EN bit is not stored and reads 0.

Test Plan:
- Reset, then read STATUS of ch0 (addr 1) -> data_in = 16'h000A; read LEVEL (addr 3) -> 16'h0000; rx_ready = 2'b11; tx_valid = 0.
- Host writes 16'hA5A5 then 16'h0001 to ch1 DATA (addr 4), each strobe held 5 clk, tx_ready = 0 -> LEVEL (addr 7) = 16'h0002; tx_data[31:16] = 16'hA5A5. Raise tx_ready for 2 clk -> tx_valid[1] falls, LEVEL = 0.
- Fabric pushes 8 words 16'h0010..16'h0017 into ch0 RX -> rx_ready[0] drops after the 8th. Nine host reads of addr 0 -> 16'h0010..16'h0017, then 0; STATUS bit5 set; CTRL write 16'h0010 clears it.
- 9 host writes to ch0 DATA with tx_ready = 0 -> LEVEL[7:0] = 8; STATUS bit4 = 1; the 9th word is absent when drained. CTRL write 16'h0001 -> LEVEL = 0 with the stickies unchanged.
- Fabric push and host pop on the same clk with RX holding 3 words -> level stays 3; read order preserved. Same-cycle flush and push -> level 0.
- With GPMC_MBOX_IRQ_EN: CTRL ch1 = 16'h0004, push one RX word -> irq = 1 one clk later; pop it -> irq = 0. Access to unmapped addr 8 (NUM_CH=2) -> reads 0, no state change.

Source files
------------

// File: rtl/gpmc_mbox_bank_if.sv
// gpmc_mbox_bank_if: the clk-domain GPMC bus as gpmc_sync presents it.
// The host side (gpmc_sync or a testbench) drives strobes, address and write
// data; the mailbox bank returns registered read data on data_in.
interface gpmc_mbox_bank_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
);
  logic                  cs;        // chip select, active low
  logic                  we;        // write strobe, active low
  logic                  oe;        // output enable, active low
  logic [ADDR_WIDTH-1:0] address;   // word address
  logic [DATA_WIDTH-1:0] data_out;  // host write data
  logic [DATA_WIDTH-1:0] data_in;   // host read data

  modport master (
    output cs, we, oe, address, data_out,
    input  data_in
  );

  modport slave (
    input  cs, we, oe, address, data_out,
    output data_in
  );
endinterface

// File: rtl/gpmc_mbox_bank.sv
// gpmc_mbox_bank: NUM_CH mailbox channels behind the GPMC bus. Each channel
// owns a host-to-fabric TX FIFO and a fabric-to-host RX FIFO plus DATA,
// STATUS, CTRL and LEVEL registers at word offsets 0..3 of its 4-word window.
// Optional feature macro: GPMC_MBOX_IRQ_EN adds the registered irq output and
// the per-channel IRQ_EN control bit. Without it there is no irq port and
// IRQ_EN reads 0. LEVEL packs two 8-bit counts, so DATA_WIDTH is at least 16.
module gpmc_mbox_bank #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  gpmc_mbox_bank_if.slave              bus,
  output logic [NUM_CH*DATA_WIDTH-1:0] tx_data,
  output logic [NUM_CH-1:0]            tx_valid,
  input  logic [NUM_CH-1:0]            tx_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0] rx_data,
  input  logic [NUM_CH-1:0]            rx_valid,
  output logic [NUM_CH-1:0]            rx_ready
`ifdef GPMC_MBOX_IRQ_EN
  ,
  output logic                         irq
`endif
);

  localparam int CH_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CHW     = CH_BITS + 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CHW-1:0]   NUM_CH_C = CHW'(NUM_CH);

  typedef enum logic [1:0] {
    OFF_DATA   = 2'd0,
    OFF_STATUS = 2'd1,
    OFF_CTRL   = 2'd2,
    OFF_LEVEL  = 2'd3
  } reg_off_e;

  // ---------------------------------------------------------------------------
  // Strobe qualification
  // ---------------------------------------------------------------------------
  logic wr_act, rd_act;
  logic wr_act_q, rd_act_q;
  logic arm_q;  // low for the first cycle after reset so a held strobe is no edge
  logic wr_stb, rd_stb;

  assign wr_act = !bus.cs && !bus.we &&  bus.oe;
  assign rd_act = !bus.cs &&  bus.we && !bus.oe;
  assign wr_stb = wr_act && !wr_act_q && arm_q;
  assign rd_stb = rd_act && !rd_act_q && arm_q;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [CH_BITS-1:0]    ch;
  reg_off_e              off;
  logic [ADDR_WIDTH-1:0] addr_hi;
  logic                  mapped;

  assign ch      = bus.address[CH_BITS+1:2];
  assign off     = reg_off_e'(bus.address[1:0]);
  assign addr_hi = bus.address >> (CH_BITS + 2);
  assign mapped  = (addr_hi == '0) && ({1'b0, ch} < NUM_CH_C);

  // ---------------------------------------------------------------------------
  // Channel state
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] tx_mem_q [NUM_CH][FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] rx_mem_q [NUM_CH][FIFO_DEPTH];
  logic [PTR_W-1:0]      tx_wr_ptr_q [NUM_CH];
  logic [PTR_W-1:0]      tx_rd_ptr_q [NUM_CH];
  logic [PTR_W-1:0]      rx_wr_ptr_q [NUM_CH];
  logic [PTR_W-1:0]      rx_rd_ptr_q [NUM_CH];
  logic [CNT_W-1:0]      tx_cnt_q    [NUM_CH];
  logic [CNT_W-1:0]      rx_cnt_q    [NUM_CH];
  logic [NUM_CH-1:0]     tx_ovf_q, rx_udf_q;
  logic [NUM_CH-1:0]     irq_en;
  logic [DATA_WIDTH-1:0] data_in_q;

  // Per-channel events for this cycle
  logic [NUM_CH-1:0] sel;
  logic [NUM_CH-1:0] tx_full, tx_empty, rx_full, rx_empty;
  logic [NUM_CH-1:0] tx_push, tx_pop, tx_ovf_set;
  logic [NUM_CH-1:0] rx_push, rx_pop, rx_udf_set;
  logic [NUM_CH-1:0] ctrl_wr, tx_flush, rx_flush, ovf_clr, udf_clr;
  logic [DATA_WIDTH-1:0] rd_val;

  // Decode host and fabric events per channel and build the read mux value.
  // NOTE: every output of this block gets a default first so no path leaves a
  // value held, which would otherwise infer a latch.
  always_comb begin
    sel        = '0;
    tx_full    = '0;
    tx_empty   = '0;
    rx_full    = '0;
    rx_empty   = '0;
    tx_push    = '0;
    tx_pop     = '0;
    tx_ovf_set = '0;
    rx_push    = '0;
    rx_pop     = '0;
    rx_udf_set = '0;
    ctrl_wr    = '0;
    tx_flush   = '0;
    rx_flush   = '0;
    ovf_clr    = '0;
    udf_clr    = '0;
    tx_data    = '0;
    tx_valid   = '0;
    rx_ready   = '0;
    rd_val     = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      sel[c]      = mapped && (ch == CH_BITS'(c));
      tx_full[c]  = (tx_cnt_q[c] == DEPTH_C);
      tx_empty[c] = (tx_cnt_q[c] == '0);
      rx_full[c]  = (rx_cnt_q[c] == DEPTH_C);
      rx_empty[c] = (rx_cnt_q[c] == '0);

      tx_valid[c] = !tx_empty[c];
      rx_ready[c] = !rx_full[c];
      tx_data[c*DATA_WIDTH +: DATA_WIDTH] = tx_mem_q[c][tx_rd_ptr_q[c]];

      // A full TX still accepts a host word when the fabric pops that cycle.
      tx_pop[c]     = !tx_empty[c] && tx_ready[c];
      tx_push[c]    = wr_stb && sel[c] && (off == OFF_DATA) && (!tx_full[c] || tx_pop[c]);
      tx_ovf_set[c] = wr_stb && sel[c] && (off == OFF_DATA) && tx_full[c] && !tx_pop[c];

      rx_push[c]    = rx_valid[c] && !rx_full[c];
      rx_pop[c]     = rd_stb && sel[c] && (off == OFF_DATA) && !rx_empty[c];
      rx_udf_set[c] = rd_stb && sel[c] && (off == OFF_DATA) && rx_empty[c];

      ctrl_wr[c]  = wr_stb && sel[c] && (off == OFF_CTRL);
      tx_flush[c] = ctrl_wr[c] && bus.data_out[0];
      rx_flush[c] = ctrl_wr[c] && bus.data_out[1];
      ovf_clr[c]  = ctrl_wr[c] && bus.data_out[3];
      udf_clr[c]  = ctrl_wr[c] && bus.data_out[4];

      if (sel[c]) begin
        unique case (off)
          OFF_DATA:   rd_val = rx_empty[c] ? '0 : rx_mem_q[c][rx_rd_ptr_q[c]];
          OFF_STATUS: rd_val = DATA_WIDTH'({rx_udf_q[c], tx_ovf_q[c], rx_empty[c],
                                            rx_full[c], tx_empty[c], tx_full[c]});
          OFF_CTRL:   rd_val = DATA_WIDTH'({irq_en[c], 2'b00});
          OFF_LEVEL:  rd_val = DATA_WIDTH'({8'(rx_cnt_q[c]), 8'(tx_cnt_q[c])});
        endcase
      end
    end
  end

  // Bus-side registers: edge detectors, reset arming and registered read data.
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arm_q     <= 1'b0;
      wr_act_q  <= 1'b0;
      rd_act_q  <= 1'b0;
      data_in_q <= '0;
    end else begin
      arm_q    <= 1'b1;
      wr_act_q <= wr_act;
      rd_act_q <= rd_act;
      if (!rd_act) begin
        data_in_q <= '0;
      end else if (rd_stb) begin
        data_in_q <= rd_val;
      end
    end
  end

  assign bus.data_in = data_in_q;

  // FIFO storage writes.
  // NOTE: the data arrays are not reset; pointers and counts define validity,
  // and leaving the RAM unreset lets it map onto plain memory.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (tx_push[c]) begin
        tx_mem_q[c][tx_wr_ptr_q[c]] <= bus.data_out;
      end
      if (rx_push[c] && !rx_flush[c]) begin
        rx_mem_q[c][rx_wr_ptr_q[c]] <= rx_data[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // FIFO pointers and counts; a flush overrides any push or pop that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        tx_wr_ptr_q[c] <= '0;
        tx_rd_ptr_q[c] <= '0;
        tx_cnt_q[c]    <= '0;
        rx_wr_ptr_q[c] <= '0;
        rx_rd_ptr_q[c] <= '0;
        rx_cnt_q[c]    <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (tx_flush[c]) begin
          tx_wr_ptr_q[c] <= '0;
          tx_rd_ptr_q[c] <= '0;
          tx_cnt_q[c]    <= '0;
        end else begin
          if (tx_push[c]) tx_wr_ptr_q[c] <= tx_wr_ptr_q[c] + 1'b1;
          if (tx_pop[c])  tx_rd_ptr_q[c] <= tx_rd_ptr_q[c] + 1'b1;
          tx_cnt_q[c] <= tx_cnt_q[c] + CNT_W'(tx_push[c]) - CNT_W'(tx_pop[c]);
        end
        if (rx_flush[c]) begin
          rx_wr_ptr_q[c] <= '0;
          rx_rd_ptr_q[c] <= '0;
          rx_cnt_q[c]    <= '0;
        end else begin
          if (rx_push[c]) rx_wr_ptr_q[c] <= rx_wr_ptr_q[c] + 1'b1;
          if (rx_pop[c])  rx_rd_ptr_q[c] <= rx_rd_ptr_q[c] + 1'b1;
          rx_cnt_q[c] <= rx_cnt_q[c] + CNT_W'(rx_push[c]) - CNT_W'(rx_pop[c]);
        end
      end
    end
  end

  // Sticky error flags: set by overflow/underflow, cleared only by CTRL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_ovf_q <= '0;
      rx_udf_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ovf_clr[c])         tx_ovf_q[c] <= 1'b0;
        else if (tx_ovf_set[c]) tx_ovf_q[c] <= 1'b1;
        if (udf_clr[c])         rx_udf_q[c] <= 1'b0;
        else if (rx_udf_set[c]) rx_udf_q[c] <= 1'b1;
      end
    end
  end

`ifdef GPMC_MBOX_IRQ_EN
  logic [NUM_CH-1:0] irq_en_q;
  logic              irq_q;

  // IRQ_EN bits follow every CTRL write to their channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_en_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ctrl_wr[c]) irq_en_q[c] <= bus.data_out[2];
      end
    end
  end

  // Interrupt registered from the current channel state, one clk behind it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |(irq_en_q & (~rx_empty | tx_ovf_q | rx_udf_q));
    end
  end

  assign irq_en = irq_en_q;
  assign irq    = irq_q;
`else
  assign irq_en = '0;
`endif

endmodule

// File: tb/tb_gpmc_mbox_bank.sv
// tb_gpmc_mbox_bank: directed bench for gpmc_mbox_bank with default
// parameters (16-bit data, 4-bit address, 2 channels, 8-deep FIFOs).
// A table of host register accesses runs first, followed by hand-written
// sequences for FIFO fill/drain, same-cycle push/pop, flush and reset corners.
// IRQ checks are compiled in when GPMC_MBOX_IRQ_EN is defined.
module tb_gpmc_mbox_bank;

  logic        clk;
  logic        rst;
  logic [31:0] tx_data;
  logic [1:0]  tx_valid;
  logic [1:0]  tx_ready;
  logic [31:0] rx_data;
  logic [1:0]  rx_valid;
  logic [1:0]  rx_ready;
`ifdef GPMC_MBOX_IRQ_EN
  logic        irq;
  localparam logic [15:0] IRQ_EN_RB = 16'h0004;
`else
  localparam logic [15:0] IRQ_EN_RB = 16'h0000;
`endif

  int n_checks = 0;
  int n_errors = 0;

  gpmc_mbox_bank_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) bus ();

  gpmc_mbox_bank #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(4),
    .NUM_CH(2),
    .FIFO_DEPTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready)
`ifdef GPMC_MBOX_IRQ_EN
    ,
    .irq(irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Single host write; strobe held for 5 clk edges.
  task automatic host_write(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.address  = a;
    bus.data_out = d;
    bus.cs = 1'b0; bus.we = 1'b0; bus.oe = 1'b1;
    repeat (5) @(negedge clk);
    bus.cs = 1'b1; bus.we = 1'b1;
  endtask

  // Single host read; strobe held for 3 clk edges, data sampled before release.
  task automatic host_read(input logic [3:0] a, output logic [15:0] d);
    @(negedge clk);
    bus.address = a;
    bus.cs = 1'b0; bus.we = 1'b1; bus.oe = 1'b0;
    repeat (3) @(negedge clk);
    d = bus.data_in;
    bus.cs = 1'b1; bus.oe = 1'b1;
  endtask

  task automatic read_check(input string name, input logic [3:0] a, input logic [15:0] exp);
    logic [15:0] d;
    host_read(a, d);
    check(name, {16'h0, d}, {16'h0, exp});
  endtask

  typedef struct packed {
    logic        is_wr;
    logic [3:0]  addr;
    logic [15:0] data;  // write data, or expected read data
  } vec_t;

  vec_t vecs [0:17];

  initial begin
    logic [15:0] d;

    vecs[0]  = '{1'b0, 4'd1,  16'h000A};  // ch0 STATUS after reset
    vecs[1]  = '{1'b0, 4'd3,  16'h0000};  // ch0 LEVEL after reset
    vecs[2]  = '{1'b0, 4'd5,  16'h000A};  // ch1 STATUS after reset
    vecs[3]  = '{1'b1, 4'd4,  16'hA5A5};  // ch1 DATA push
    vecs[4]  = '{1'b1, 4'd4,  16'h0001};  // ch1 DATA push
    vecs[5]  = '{1'b0, 4'd7,  16'h0002};  // ch1 LEVEL: two TX words
    vecs[6]  = '{1'b0, 4'd5,  16'h0008};  // ch1 STATUS: TX neither full nor empty
    vecs[7]  = '{1'b1, 4'd8,  16'hFFFF};  // unmapped write, ignored
    vecs[8]  = '{1'b0, 4'd8,  16'h0000};  // unmapped read
    vecs[9]  = '{1'b0, 4'd12, 16'h0000};  // unmapped read
    vecs[10] = '{1'b0, 4'd7,  16'h0002};  // ch1 LEVEL unchanged
    vecs[11] = '{1'b1, 4'd6,  16'h0004};  // ch1 CTRL IRQ_EN
    vecs[12] = '{1'b0, 4'd6,  IRQ_EN_RB}; // ch1 CTRL readback
    vecs[13] = '{1'b0, 4'd2,  16'h0000};  // ch0 CTRL
    vecs[14] = '{1'b0, 4'd0,  16'h0000};  // ch0 DATA on empty RX -> underflow
    vecs[15] = '{1'b0, 4'd1,  16'h002A};  // ch0 STATUS with RX_UDF
    vecs[16] = '{1'b1, 4'd2,  16'h0010};  // ch0 clear RX_UDF
    vecs[17] = '{1'b0, 4'd1,  16'h000A};  // ch0 STATUS clean

    rst = 1'b1;
    bus.cs = 1'b1; bus.we = 1'b1; bus.oe = 1'b1;
    bus.address = '0; bus.data_out = '0;
    tx_ready = '0; rx_valid = '0; rx_data = '0;

    repeat (3) @(negedge clk);
    check("reset data_in", {16'h0, bus.data_in}, 32'h0);
    check("reset tx_valid", {30'h0, tx_valid}, 32'h0);
    check("reset rx_ready", {30'h0, rx_ready}, 32'h3);
`ifdef GPMC_MBOX_IRQ_EN
    check("reset irq", {31'h0, irq}, 32'h0);
`endif
    rst = 1'b0;

    // Table of host accesses
    for (int i = 0; i <= 17; i++) begin
      if (vecs[i].is_wr) begin
        host_write(vecs[i].addr, vecs[i].data);
      end else begin
        read_check($sformatf("vec%0d addr%0d", i, vecs[i].addr), vecs[i].addr, vecs[i].data);
      end
    end

    // ch1 TX head and drain by the fabric over 2 clk
    check("ch1 tx_valid", {30'h0, tx_valid}, 32'h2);
    check("ch1 tx head 0", {16'h0, tx_data[31:16]}, 32'hA5A5);
    @(negedge clk); tx_ready = 2'b10;
    @(negedge clk);
    check("ch1 tx head 1", {16'h0, tx_data[31:16]}, 32'h0001);
    @(negedge clk); tx_ready = 2'b00;
    check("ch1 tx drained", {30'h0, tx_valid}, 32'h0);
    read_check("ch1 level drained", 4'd7, 16'h0000);

    // ch0 RX fill to full from the fabric
    @(negedge clk); rx_valid = 2'b01;
    for (int i = 0; i < 8; i++) begin
      rx_data[15:0] = 16'h0010 + 16'(i);
      check($sformatf("rx_ready before push %0d", i), {31'h0, rx_ready[0]}, 32'h1);
      @(negedge clk);
    end
    rx_valid = 2'b00;
    check("rx_ready full", {31'h0, rx_ready[0]}, 32'h0);
    read_check("ch0 level rx full", 4'd3, 16'h0800);
    read_check("ch0 status rx full", 4'd1, 16'h0006);
    for (int i = 0; i < 9; i++) begin
      read_check($sformatf("ch0 rx pop %0d", i), 4'd0, (i < 8) ? 16'h0010 + 16'(i) : 16'h0000);
    end
    read_check("ch0 status udf", 4'd1, 16'h002A);
    host_write(4'd2, 16'h0010);
    read_check("ch0 status udf cleared", 4'd1, 16'h000A);

    // ch0 TX overflow, drain order, flush keeps stickies
    for (int i = 0; i < 9; i++) host_write(4'd0, 16'h0100 + 16'(i));
    read_check("ch0 level tx full", 4'd3, 16'h0008);
    read_check("ch0 status ovf", 4'd1, 16'h0019);
    @(negedge clk); tx_ready = 2'b01;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("ch0 drain %0d", i), {15'h0, tx_valid[0], tx_data[15:0]},
            {15'h0, 1'b1, 16'h0100 + 16'(i)});
      @(negedge clk);
    end
    tx_ready = 2'b00;
    check("ch0 9th word absent", {31'h0, tx_valid[0]}, 32'h0);
    for (int i = 0; i < 3; i++) host_write(4'd0, 16'h0150 + 16'(i));
    host_write(4'd2, 16'h0001);
    read_check("ch0 level after tx flush", 4'd3, 16'h0000);
    read_check("ch0 status after tx flush", 4'd1, 16'h001A);
    host_write(4'd2, 16'h0008);
    read_check("ch0 status ovf cleared", 4'd1, 16'h000A);

    // Host push and fabric pop together while TX is full
    for (int i = 0; i < 8; i++) host_write(4'd0, 16'h0200 + 16'(i));
    @(negedge clk);
    bus.address = 4'd0; bus.data_out = 16'h02FF;
    bus.cs = 1'b0; bus.we = 1'b0; bus.oe = 1'b1;
    tx_ready = 2'b01;
    @(negedge clk); tx_ready = 2'b00;
    repeat (3) @(negedge clk);
    bus.cs = 1'b1; bus.we = 1'b1;
    read_check("ch0 level full push+pop", 4'd3, 16'h0008);
    read_check("ch0 status no ovf", 4'd1, 16'h0009);
    check("ch0 head after push+pop", {16'h0, tx_data[15:0]}, 32'h0201);
    host_write(4'd2, 16'h0001);

    // Fabric push and host pop on the same clk with RX holding 3 words
    @(negedge clk); rx_valid = 2'b01;
    for (int i = 0; i < 3; i++) begin
      rx_data[15:0] = 16'h0020 + 16'(i);
      @(negedge clk);
    end
    rx_valid = 2'b00;
    @(negedge clk);
    bus.address = 4'd0;
    bus.cs = 1'b0; bus.we = 1'b1; bus.oe = 1'b0;
    rx_valid = 2'b01; rx_data[15:0] = 16'h0023;
    @(negedge clk); rx_valid = 2'b00;
    repeat (2) @(negedge clk);
    check("same-cycle pop data", {16'h0, bus.data_in}, 32'h0020);
    bus.cs = 1'b1; bus.oe = 1'b1;
    @(negedge clk);
    check("data_in idle zero", {16'h0, bus.data_in}, 32'h0);
    read_check("ch0 level push+pop", 4'd3, 16'h0300);
    for (int i = 1; i < 4; i++) begin
      read_check($sformatf("ch0 order %0d", i), 4'd0, 16'h0020 + 16'(i));
    end

    // RX flush in the same cycle as a fabric push
    @(negedge clk); rx_valid = 2'b01;
    for (int i = 0; i < 2; i++) begin
      rx_data[15:0] = 16'h0030 + 16'(i);
      @(negedge clk);
    end
    bus.address = 4'd2; bus.data_out = 16'h0002;
    bus.cs = 1'b0; bus.we = 1'b0; bus.oe = 1'b1;
    rx_data[15:0] = 16'h0032;
    @(negedge clk); rx_valid = 2'b00;
    repeat (3) @(negedge clk);
    bus.cs = 1'b1; bus.we = 1'b1;
    read_check("ch0 level flush+push", 4'd3, 16'h0000);
    read_check("ch0 status flush+push", 4'd1, 16'h000A);

    // ch1 RX word: irq follows one clk behind the level change
`ifdef GPMC_MBOX_IRQ_EN
    check("irq idle", {31'h0, irq}, 32'h0);
`endif
    @(negedge clk); rx_valid = 2'b10; rx_data[31:16] = 16'h0077;
    @(negedge clk); rx_valid = 2'b00;
`ifdef GPMC_MBOX_IRQ_EN
    check("irq lag", {31'h0, irq}, 32'h0);
`endif
    @(negedge clk);
`ifdef GPMC_MBOX_IRQ_EN
    check("irq set", {31'h0, irq}, 32'h1);
`endif
    read_check("ch1 rx pop", 4'd4, 16'h0077);
`ifdef GPMC_MBOX_IRQ_EN
    check("irq cleared", {31'h0, irq}, 32'h0);
`endif

    // Reset during a held write strobe: no push once reset releases
    host_write(4'd4, 16'h1234);
    @(negedge clk); rst = 1'b1;
    bus.address = 4'd4; bus.data_out = 16'h9999;
    bus.cs = 1'b0; bus.we = 1'b0; bus.oe = 1'b1;
    repeat (2) @(negedge clk);
    check("mid reset tx_valid", {30'h0, tx_valid}, 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    bus.cs = 1'b1; bus.we = 1'b1;
    check("held strobe no push", {30'h0, tx_valid}, 32'h0);
    read_check("ch1 level after reset", 4'd7, 16'h0000);
    read_check("ch1 ctrl after reset", 4'd6, 16'h0000);
    host_write(4'd4, 16'h4321);
    check("fresh edge push", {16'h0, tx_data[31:16]}, 32'h4321);
    read_check("ch1 level fresh edge", 4'd7, 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
